// File: rtl/axis_complex_weighter.sv
// axis_complex_weighter
//   Per-channel beamforming weight stage. Joins one channel's real and imag
//   AXI-Stream inputs, multiplies every signed sample by one complex weight,
//   and emits rounded, saturated real and imag AXI-Stream outputs.
//
// Ports
//   clock, resetn              single rising-edge clock, async active-low reset
//   s_axis_real_*              real sample input (tlast is authoritative)
//   s_axis_imag_*              imag sample input (tlast only cross-checked)
//   weight_re/im, weight_load  new complex weight, 1-cycle load strobe
//   m_axis_real_*              weighted real output
//   m_axis_imag_*              weighted imag output
//   tlast_mismatch             sticky: real/imag tlast differed on an accepted beat
//
// Pipeline: S1 (samples + weight) -> S2 (4 products) -> output register
// (sum, round, saturate). A stage loads when empty or when the next one loads.
module axis_complex_weighter #(
  parameter int unsigned SDATA_WIDTH   = 128,
  parameter int unsigned SSAMPLE_WIDTH = 16,
  parameter int unsigned WEIGHT_WIDTH  = 8,
  parameter int unsigned SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH,
  parameter logic signed [WEIGHT_WIDTH-1:0] DEFAULT_WRE = 8'sh7F,
  parameter logic signed [WEIGHT_WIDTH-1:0] DEFAULT_WIM = 8'sh00
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [SDATA_WIDTH-1:0]    s_axis_real_tdata,
  input  logic                      s_axis_real_tvalid,
  output logic                      s_axis_real_tready,
  input  logic                      s_axis_real_tlast,
  input  logic [SDATA_WIDTH-1:0]    s_axis_imag_tdata,
  input  logic                      s_axis_imag_tvalid,
  output logic                      s_axis_imag_tready,
  input  logic                      s_axis_imag_tlast,
  input  logic [WEIGHT_WIDTH-1:0]   weight_re,
  input  logic [WEIGHT_WIDTH-1:0]   weight_im,
  input  logic                      weight_load,
  output logic [SDATA_WIDTH-1:0]    m_axis_real_tdata,
  output logic [SDATA_WIDTH/8-1:0]  m_axis_real_tkeep,
  output logic                      m_axis_real_tvalid,
  input  logic                      m_axis_real_tready,
  output logic                      m_axis_real_tlast,
  output logic [SDATA_WIDTH-1:0]    m_axis_imag_tdata,
  output logic [SDATA_WIDTH/8-1:0]  m_axis_imag_tkeep,
  output logic                      m_axis_imag_tvalid,
  input  logic                      m_axis_imag_tready,
  output logic                      m_axis_imag_tlast,
  output logic                      tlast_mismatch
);

  localparam int unsigned SW_ = SSAMPLE_WIDTH;
  localparam int unsigned WW  = WEIGHT_WIDTH;
  localparam int unsigned PW  = SW_ + WW;          // exact product width
  localparam int unsigned AW  = PW + 1;            // exact sum/difference width
  localparam int unsigned RW  = AW + 2 - WW;       // width after round and shift
  localparam int unsigned KW  = SDATA_WIDTH / 8;
  localparam logic [AW:0] RND = (AW + 1)'(1) << (WW - 2);

  // Round half up by adding 2^(W-2), shift by W-1, then clamp to the sample range.
  function automatic logic [SW_-1:0] round_sat(input logic [AW-1:0] x);
    logic [AW:0]   t;
    logic [RW-1:0] s;
    t = {x[AW-1], x} + RND;
    s = t[AW:WW-1];
    if ((&s[RW-1:SW_-1]) || !(|s[RW-1:SW_-1])) begin
      return s[SW_-1:0];
    end else if (s[RW-1]) begin
      return {1'b1, {(SW_-1){1'b0}}};
    end else begin
      return {1'b0, {(SW_-1){1'b1}}};
    end
  endfunction

  // Stage registers
  logic                         s1_valid, s1_last;
  logic [SDATA_WIDTH-1:0]       s1_re, s1_im;
  logic signed [WW-1:0]         s1_wr, s1_wi;
  logic                         s2_valid, s2_last;
  logic signed [PW-1:0]         s2_rr [SAMPLES];
  logic signed [PW-1:0]         s2_ii [SAMPLES];
  logic signed [PW-1:0]         s2_ri [SAMPLES];
  logic signed [PW-1:0]         s2_ir [SAMPLES];
  logic                         out_valid, out_last, real_done, imag_done;
  logic [SDATA_WIDTH-1:0]       out_re, out_im;

  // Weight control
  logic signed [WW-1:0]         act_wr, act_wi, pend_wr, pend_wi;
  logic                         pending, in_packet, mismatch;

  // Handshake plumbing
  logic real_xfer, imag_xfer, out_release, out_ready, s2_ready, s1_can_load, in_accept;

  assign m_axis_real_tvalid = out_valid && !real_done;
  assign m_axis_imag_tvalid = out_valid && !imag_done;
  assign real_xfer   = m_axis_real_tvalid && m_axis_real_tready;
  assign imag_xfer   = m_axis_imag_tvalid && m_axis_imag_tready;
  // Output register frees once each stream has taken the beat, possibly this cycle.
  assign out_release = out_valid && (real_done || real_xfer) && (imag_done || imag_xfer);
  assign out_ready   = !out_valid || out_release;
  assign s2_ready    = !s2_valid || out_ready;
  assign s1_can_load = !s1_valid || s2_ready;
  assign in_accept   = s1_can_load && s_axis_real_tvalid && s_axis_imag_tvalid;

  assign s_axis_real_tready = in_accept;
  assign s_axis_imag_tready = in_accept;

  assign m_axis_real_tdata = out_re;
  assign m_axis_imag_tdata = out_im;
  assign m_axis_real_tlast = out_last;
  assign m_axis_imag_tlast = out_last;
  assign m_axis_real_tkeep = {KW{m_axis_real_tvalid}};
  assign m_axis_imag_tkeep = {KW{m_axis_imag_tvalid}};
  assign tlast_mismatch    = mismatch;

  // S1: capture samples with the weight active at acceptance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_wr    <= '0;
      s1_wi    <= '0;
    end else if (s1_can_load) begin
      s1_valid <= in_accept;
      if (in_accept) begin
        s1_last <= s_axis_real_tlast;
        s1_re   <= s_axis_real_tdata;
        s1_im   <= s_axis_imag_tdata;
        s1_wr   <= act_wr;
        s1_wi   <= act_wi;
      end
    end
  end

  // S2: four exact products per sample.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      for (int i = 0; i < SAMPLES; i++) begin
        s2_rr[i] <= '0;
        s2_ii[i] <= '0;
        s2_ri[i] <= '0;
        s2_ir[i] <= '0;
      end
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        for (int i = 0; i < SAMPLES; i++) begin
          s2_rr[i] <= $signed(s1_re[i*SW_ +: SW_]) * s1_wr;
          s2_ii[i] <= $signed(s1_im[i*SW_ +: SW_]) * s1_wi;
          s2_ri[i] <= $signed(s1_re[i*SW_ +: SW_]) * s1_wi;
          s2_ir[i] <= $signed(s1_im[i*SW_ +: SW_]) * s1_wr;
        end
      end
    end
  end

  // S3 combinational: re = ar*wr - ai*wi, im = ar*wi + ai*wr, then round/saturate.
  logic [SDATA_WIDTH-1:0] out_re_d, out_im_d;
  logic [AW-1:0]          sum_re, sum_im;

  always_comb begin
    out_re_d = '0;
    out_im_d = '0;
    sum_re   = '0;
    sum_im   = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      sum_re = {s2_rr[i][PW-1], s2_rr[i]} - {s2_ii[i][PW-1], s2_ii[i]};
      sum_im = {s2_ri[i][PW-1], s2_ri[i]} + {s2_ir[i][PW-1], s2_ir[i]};
      out_re_d[i*SW_ +: SW_] = round_sat(sum_re);
      out_im_d[i*SW_ +: SW_] = round_sat(sum_im);
    end
  end

  // Output register with per-stream done bits so each side can drain independently.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      real_done <= 1'b0;
      imag_done <= 1'b0;
    end else if (out_ready) begin
      out_valid <= s2_valid;
      real_done <= 1'b0;
      imag_done <= 1'b0;
      if (s2_valid) begin
        out_last <= s2_last;
        out_re   <= out_re_d;
        out_im   <= out_im_d;
      end
    end else begin
      if (real_xfer) real_done <= 1'b1;
      if (imag_xfer) imag_done <= 1'b1;
    end
  end

  // Weight swap only between packets. A load landing on a non-last accepted beat
  // is treated as in-packet so the packet keeps one weight throughout.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      act_wr    <= DEFAULT_WRE;
      act_wi    <= DEFAULT_WIM;
      pend_wr   <= '0;
      pend_wi   <= '0;
      pending   <= 1'b0;
      in_packet <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      if (in_accept) begin
        in_packet <= !s_axis_real_tlast;
        if (s_axis_real_tlast != s_axis_imag_tlast) mismatch <= 1'b1;
      end
      if (weight_load) begin
        if (in_accept && s_axis_real_tlast) begin
          act_wr  <= weight_re;
          act_wi  <= weight_im;
          pending <= 1'b0;
        end else if (in_packet || in_accept) begin
          pend_wr <= weight_re;
          pend_wi <= weight_im;
          pending <= 1'b1;
        end else begin
          act_wr <= weight_re;
          act_wi <= weight_im;
        end
      end else if (in_accept && s_axis_real_tlast && pending) begin
        act_wr  <= pend_wr;
        act_wi  <= pend_wi;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_complex_weighter.sv
module tb_axis_complex_weighter;
  localparam int DW = 128;
  localparam int NS = 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0]   s_axis_real_tdata = '0, s_axis_imag_tdata = '0;
  logic            s_axis_real_tvalid = 0, s_axis_imag_tvalid = 0;
  logic            s_axis_real_tready, s_axis_imag_tready;
  logic            s_axis_real_tlast = 0, s_axis_imag_tlast = 0;
  logic [7:0]      weight_re = '0, weight_im = '0;
  logic            weight_load = 0;
  logic [DW-1:0]   m_axis_real_tdata, m_axis_imag_tdata;
  logic [DW/8-1:0] m_axis_real_tkeep, m_axis_imag_tkeep;
  logic            m_axis_real_tvalid, m_axis_imag_tvalid;
  logic            m_axis_real_tready = 1, m_axis_imag_tready = 1;
  logic            m_axis_real_tlast, m_axis_imag_tlast;
  logic            tlast_mismatch;

  axis_complex_weighter dut (
    .clock(clock), .resetn(resetn),
    .s_axis_real_tdata(s_axis_real_tdata), .s_axis_real_tvalid(s_axis_real_tvalid),
    .s_axis_real_tready(s_axis_real_tready), .s_axis_real_tlast(s_axis_real_tlast),
    .s_axis_imag_tdata(s_axis_imag_tdata), .s_axis_imag_tvalid(s_axis_imag_tvalid),
    .s_axis_imag_tready(s_axis_imag_tready), .s_axis_imag_tlast(s_axis_imag_tlast),
    .weight_re(weight_re), .weight_im(weight_im), .weight_load(weight_load),
    .m_axis_real_tdata(m_axis_real_tdata), .m_axis_real_tkeep(m_axis_real_tkeep),
    .m_axis_real_tvalid(m_axis_real_tvalid), .m_axis_real_tready(m_axis_real_tready),
    .m_axis_real_tlast(m_axis_real_tlast),
    .m_axis_imag_tdata(m_axis_imag_tdata), .m_axis_imag_tkeep(m_axis_imag_tkeep),
    .m_axis_imag_tvalid(m_axis_imag_tvalid), .m_axis_imag_tready(m_axis_imag_tready),
    .m_axis_imag_tlast(m_axis_imag_tlast),
    .tlast_mismatch(tlast_mismatch)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [DW:0] exp_r[$];
  logic [DW:0] exp_i[$];
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer arithmetic, round half up, clamp.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                                          input logic [7:0] wr, input logic [7:0] wi,
                                          input bit want_im);
    logic [DW-1:0] r;
    int a, b, c, d, x;
    r = '0;
    c = int'($signed(wr));
    d = int'($signed(wi));
    for (int i = 0; i < NS; i++) begin
      a = int'($signed(ar[i*16 +: 16]));
      b = int'($signed(ai[i*16 +: 16]));
      x = want_im ? (a * d + b * c) : (a * c - b * d);
      x = (x + 64) >>> 7;
      if (x > 32767) x = 32767;
      if (x < -32768) x = -32768;
      r[i*16 +: 16] = x[15:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    case (rdy_mode)
      0: begin m_axis_real_tready = 1'b1; m_axis_imag_tready = 1'b1; end
      1: begin
        m_axis_real_tready = 1'($urandom_range(0, 1));
        m_axis_imag_tready = 1'($urandom_range(0, 1));
      end
      default: begin m_axis_real_tready = 1'b0; m_axis_imag_tready = 1'b0; end
    endcase
  endtask

  task automatic load_weight(input logic [7:0] wr, input logic [7:0] wi);
    weight_re = wr;
    weight_im = wi;
    weight_load = 1'b1;
    tick();
    weight_load = 1'b0;
  endtask

  // Drive one beat on both inputs; ewr/ewi is the weight the beat must be scaled by.
  task automatic send(input logic [DW-1:0] ar, input logic [DW-1:0] ai, input bit lr,
                      input bit li, input logic [7:0] ewr, input logic [7:0] ewi,
                      input bit load);
    bit acc;
    int budget;
    s_axis_real_tdata = ar;
    s_axis_imag_tdata = ai;
    s_axis_real_tlast = lr;
    s_axis_imag_tlast = li;
    s_axis_real_tvalid = 1'b1;
    s_axis_imag_tvalid = 1'b1;
    weight_load = load;
    exp_r.push_back({lr, model(ar, ai, ewr, ewi, 1'b0)});
    exp_i.push_back({lr, model(ar, ai, ewr, ewi, 1'b1)});
    acc = 0;
    budget = 0;
    while (!acc && budget < 200) begin
      @(negedge clock);
      acc = s_axis_real_tready && s_axis_imag_tready;
      tick();
      budget++;
    end
    chk("accept", 256'(acc), 256'(1));
    s_axis_real_tvalid = 1'b0;
    s_axis_imag_tvalid = 1'b0;
    weight_load = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_r.size() != 0 || exp_i.size() != 0) && budget < 500) begin
      tick();
      budget++;
    end
    chk("drain", 256'(exp_r.size() + exp_i.size()), 256'(0));
  endtask

  // Output monitor: scoreboard pop on each transfer, stability while stalled.
  logic [DW:0] prev_r, prev_i, e_r, e_i;
  bit stall_r = 0, stall_i = 0;
  always @(negedge clock) begin
    if (!resetn) begin
      stall_r = 0;
      stall_i = 0;
    end else begin
      if (stall_r) chk("real_stable", {m_axis_real_tvalid, m_axis_real_tlast, m_axis_real_tdata},
                       {1'b1, prev_r});
      if (stall_i) chk("imag_stable", {m_axis_imag_tvalid, m_axis_imag_tlast, m_axis_imag_tdata},
                       {1'b1, prev_i});
      stall_r = 0;
      stall_i = 0;
      if (m_axis_real_tvalid) begin
        if (m_axis_real_tready) begin
          if (exp_r.size() == 0) chk("real_unexpected", 256'(1), 256'(0));
          else begin
            e_r = exp_r.pop_front();
            chk("real_beat", {m_axis_real_tkeep, m_axis_real_tlast, m_axis_real_tdata},
                {16'hFFFF, e_r});
          end
        end else begin
          stall_r = 1;
          prev_r = {m_axis_real_tlast, m_axis_real_tdata};
        end
      end
      if (m_axis_imag_tvalid) begin
        if (m_axis_imag_tready) begin
          if (exp_i.size() == 0) chk("imag_unexpected", 256'(1), 256'(0));
          else begin
            e_i = exp_i.pop_front();
            chk("imag_beat", {m_axis_imag_tkeep, m_axis_imag_tlast, m_axis_imag_tdata},
                {16'hFFFF, e_i});
          end
        end else begin
          stall_i = 1;
          prev_i = {m_axis_imag_tlast, m_axis_imag_tdata};
        end
      end
    end
  end

  function automatic logic [255:0] all_outs();
    return {m_axis_real_tvalid, m_axis_real_tlast, m_axis_real_tkeep, m_axis_real_tdata,
            m_axis_imag_tvalid, m_axis_imag_tlast, m_axis_imag_tkeep, m_axis_imag_tdata,
            tlast_mismatch};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v4000, vzero, v8000, v7fff, ar, ai;
    int lat;
    bit found;
    v4000 = {NS{16'h4000}};
    vzero = '0;
    v8000 = {NS{16'h8000}};
    v7fff = {NS{16'h7FFF}};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", all_outs(), '0);
    resetn = 1'b1;
    tick();

    // 1: default weight, latency
    send(v4000, vzero, 1, 1, 8'h7F, 8'h00, 0);
    lat = 0;
    found = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(negedge clock);
      if (m_axis_real_tvalid) begin
        found = 1;
        lat = k;
      end
    end
    chk("latency", 256'(lat), 256'(3));
    drain();

    // 2: purely imaginary weight
    load_weight(8'h00, 8'h7F);
    send(v4000, vzero, 1, 1, 8'h00, 8'h7F, 0);
    drain();

    // 3: saturation corners
    load_weight(8'h80, 8'h80);
    send(v8000, v8000, 1, 1, 8'h80, 8'h80, 0);
    load_weight(8'h7F, 8'h81);
    send(v7fff, v7fff, 1, 1, 8'h7F, 8'h81, 0);
    drain();

    // 4: independent random backpressure, 20 counting beats
    load_weight(8'h5A, 8'hC3);
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NS; i++) begin
        ar[i*16 +: 16] = 16'(n * 1500 + i * 37 - 15000);
        ai[i*16 +: 16] = 16'(12000 - n * 1100 + i * 53);
      end
      send(ar, ai, n == 19, n == 19, 8'h5A, 8'hC3, 0);
    end
    drain();
    rdy_mode = 0;

    // 5a: load during beat 2 of a 4-beat packet takes effect on the next packet
    weight_re = 8'h20;
    weight_im = 8'hE0;
    for (int n = 0; n < 4; n++) begin
      ar = {NS{16'(n * 3000 + 1000)}};
      ai = {NS{16'(-n * 2000 - 500)}};
      send(ar, ai, n == 3, n == 3, 8'h5A, 8'hC3, n == 2);
    end
    // 5b: load coincident with tlast acceptance
    weight_re = 8'h40;
    weight_im = 8'h40;
    send(v4000, v7fff, 0, 0, 8'h20, 8'hE0, 0);
    send(v7fff, v4000, 1, 1, 8'h20, 8'hE0, 1);
    send(v4000, v8000, 1, 1, 8'h40, 8'h40, 0);
    drain();

    // 6a: reset with beats in flight
    rdy_mode = 2;
    m_axis_real_tready = 1'b0;
    m_axis_imag_tready = 1'b0;
    send(v4000, v4000, 0, 0, 8'h40, 8'h40, 0);
    send(v7fff, v4000, 0, 0, 8'h40, 8'h40, 0);
    repeat (3) tick();
    exp_r.delete();
    exp_i.delete();
    resetn = 1'b0;
    #1;
    chk("reset_in_flight", all_outs(), '0);
    tick();
    resetn = 1'b1;
    rdy_mode = 0;
    tick();
    send(v4000, v7fff, 1, 1, 8'h7F, 8'h00, 0);
    drain();

    // 6b: tlast disagreement is sticky until reset
    chk("mismatch_clear", 256'(tlast_mismatch), 256'(0));
    send(v4000, vzero, 1, 0, 8'h7F, 8'h00, 0);
    chk("mismatch_set", 256'(tlast_mismatch), 256'(1));
    send(vzero, v4000, 1, 1, 8'h7F, 8'h00, 0);
    drain();
    chk("mismatch_hold", 256'(tlast_mismatch), 256'(1));
    resetn = 1'b0;
    #1;
    chk("mismatch_reset", 256'(tlast_mismatch), 256'(0));
    tick();
    resetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
